// File: rtl/kp_pkg.sv
// rtl/kp_pkg.sv - shared key codes, segment patterns and scan state type
package kp_pkg;

    localparam logic [3:0] CLR_CODE   = 4'hA;
    localparam logic [3:0] UP_CODE    = 4'hB;
    localparam logic [3:0] DOWN_CODE  = 4'hC;
    localparam logic [3:0] SEC_CODE   = 4'hD;
    localparam logic [3:0] HELP_CODE  = 4'hE;
    localparam logic [3:0] ENT_CODE   = 4'hF;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        SCAN_0, SCAN_1, SCAN_2, SCAN_3, SCAN_4, SCAN_5, SCAN_6, SCAN_7
    } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit code to active-low seven-segment pattern
module seg7_decode
    import kp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/kp_digit_display.sv
// rtl/kp_digit_display.sv - keypad digit entry register with multiplexed 7-seg scan
module kp_digit_display #(
    parameter int         NUM_DIGITS  = 3,
    parameter int         REFRESH_DIV = 1,
    parameter logic [3:0] CLR_CODE    = 4'hA,
    parameter logic [3:0] BLANK_CODE  = 4'hF
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    KEY_VALID,
    input  logic [3:0]              KEY_CODE,
    output logic [6:0]              SEG,
    output logic [NUM_DIGITS-1:0]   COM,
    output logic [4*NUM_DIGITS-1:0] DIGITS
);
    import kp_pkg::*;

    localparam int                    DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam scan_state_t           LAST_STATE = scan_state_t'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] COM_ONE    = NUM_DIGITS'(1);

    logic                    kv_q;
    logic                    armed;
    logic                    press;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [DIV_W-1:0]        div;
    logic                    div_wrap;
    scan_state_t             state;
    scan_state_t             state_nx;
    logic [4*NUM_DIGITS-1:0] slot_bits;
    logic [3:0]              slot_code;
    logic [6:0]              slot_seg;

    // armed stays low until KEY_VALID is seen low, so a key held through reset is ignored
    assign press = KEY_VALID & ~kv_q & armed;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            kv_q   <= 1'b0;
            armed  <= 1'b0;
            digits <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            kv_q <= KEY_VALID;
            if (!KEY_VALID) begin
                armed <= 1'b1;
            end
            if (press) begin
                if (KEY_CODE <= 4'd9) begin
                    digits <= {digits[4*NUM_DIGITS-5:0], KEY_CODE};
                end else if (KEY_CODE == CLR_CODE) begin
                    digits <= {NUM_DIGITS{BLANK_CODE}};
                end
            end
        end
    end

    assign div_wrap = (div == DIV_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div <= '0;
        end else if (div_wrap) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= SCAN_0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (div_wrap) begin
            if (state == LAST_STATE) begin
                state_nx = SCAN_0;
            end else begin
                state_nx = scan_state_t'(state + 3'd1);
            end
        end
    end

    assign slot_bits = digits >> {state, 2'b00};
    assign slot_code = slot_bits[3:0];

    seg7_decode u_seg7_decode (
        .code (slot_code),
        .seg  (slot_seg)
    );

    // Segment and common drives are registered together so they never disagree
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SEG <= SEG_BLANK;
            COM <= '1;
        end else begin
            SEG <= slot_seg;
            COM <= ~(COM_ONE << state);
        end
    end

    assign DIGITS = digits;

endmodule

// File: tb/tb_kp_digit_display.sv
// tb/tb_kp_digit_display.sv - directed self-checking bench for kp_digit_display
module tb_kp_digit_display;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        KEY_VALID = 1'b0;
    logic [3:0]  KEY_CODE = 4'h0;
    logic [6:0]  seg, seg2;
    logic [2:0]  com, com2;
    logic [11:0] digits, digits2;

    int n_checks = 0;
    int n_fail   = 0;

    kp_digit_display dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .SEG       (seg),
        .COM       (com),
        .DIGITS    (digits)
    );

    kp_digit_display #(.REFRESH_DIV(2)) dut_div2 (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .SEG       (seg2),
        .COM       (com2),
        .DIGITS    (digits2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] code, input int hi, input int lo);
        @(negedge CLK);
        KEY_VALID = 1'b1;
        KEY_CODE  = code;
        repeat (hi) @(negedge CLK);
        KEY_VALID = 1'b0;
        repeat (lo) @(negedge CLK);
    endtask

    initial begin
        logic [11:0] exp_shift [4];
        logic [2:0]  exp_com [3];
        logic [2:0]  prev;
        bit          found;

        exp_shift[0] = 12'hFF1;
        exp_shift[1] = 12'hF12;
        exp_shift[2] = 12'h123;
        exp_shift[3] = 12'h234;
        exp_com[0]   = 3'b110;
        exp_com[1]   = 3'b101;
        exp_com[2]   = 3'b011;

        // Power-on reset, before any clock edge
        #1 RESET = 1'b0;
        #1;
        check("por_seg",     seg,     7'h7F);
        check("por_com",     com,     3'b111);
        check("por_digits",  digits,  12'hFFF);
        check("por_digits2", digits2, 12'hFFF);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);

        // Shift 1,2,3,4
        for (int i = 0; i < 4; i++) begin
            press_key(4'(i + 1), 5, 5);
            check($sformatf("shift_%0d", i + 1), digits, exp_shift[i]);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (com == 3'b110) found = 1'b1;
        end
        check("scan0_found", found, 1'b1);
        check("scan0_seg", seg, 7'h19);

        // Asynchronous reset mid-scan with a non-blank register
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("rst_seg",    seg,    7'h7F);
        check("rst_com",    com,    3'b111);
        check("rst_digits", digits, 12'hFFF);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Held key produces a single shift
        press_key(4'd7, 50, 5);
        check("held_key", digits, 12'hFF7);

        // Clear, rebuild 123, hold code, then clear
        press_key(4'hA, 3, 3);
        check("clr_first", digits, 12'hFFF);
        press_key(4'd1, 2, 2);
        press_key(4'd2, 2, 2);
        press_key(4'd3, 2, 2);
        check("build_123", digits, 12'h123);
        press_key(4'hB, 3, 3);
        check("hold_B", digits, 12'h123);
        press_key(4'hA, 3, 3);
        check("clr_digits", digits, 12'hFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("clr_seg_%0d", i), seg, 7'h7F);
        end

        // REFRESH_DIV=2 scan sequence
        prev  = com2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (com2 == 3'b110 && prev != 3'b110) found = 1'b1;
            else prev = com2;
        end
        check("div2_found", found, 1'b1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("div2_com_%0d", i), com2, exp_com[(i / 2) % 3]);
            @(negedge CLK);
        end

        // Key held across reset release
        RESET     = 1'b0;
        KEY_VALID = 1'b1;
        KEY_CODE  = 4'd5;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_held_noshift", digits, 12'hFFF);
        KEY_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_held_low", digits, 12'hFFF);
        KEY_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_held_repress", digits, 12'hFF5);
        KEY_VALID = 1'b0;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
